// File: rtl/picorv32_mem_responder.sv
// Slave end of the picorv32 native memory bus: word RAM with byte lanes,
// programmable wait states, console/halt MMIO and out-of-range error flag.
module picorv32_mem_responder #(
    parameter int          MEM_WORDS   = 4096,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] MMIO_BASE   = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    input  logic        mem_instr,
    output logic        out_valid,
    output logic [7:0]  out_byte,
    output logic        halt,
    output logic        err
);
    localparam int          AW        = $clog2(MEM_WORDS);
    localparam logic [29:0] CON_ADDR  = MMIO_BASE[31:2];
    localparam logic [29:0] HALT_ADDR = CON_ADDR + 30'd1;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:2] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        instr_q, instr_d;
    logic [31:0] rdata_q, rdata_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_byte_q, out_byte_d;
    logic        halt_q, halt_d;
    logic        err_q, err_d;

    logic [31:0] ram [MEM_WORDS];

    logic [31:2] cur_addr;
    logic [31:0] cur_wdata;
    logic [3:0]  cur_wstrb;
    logic        cur_instr;
    logic        go_resp;
    logic        ram_we;
    logic        in_ram;
    logic        is_con;
    logic        is_halt;
    logic        is_wr;
    logic [AW-1:0] ram_idx;

    logic unused_addr_lsb;
    assign unused_addr_lsb = ^mem_addr[1:0];

    // With zero wait states the RESP edge is the capture edge, so the
    // decode must see the live request rather than the latched copy.
    always_comb begin
        cur_addr  = addr_q;
        cur_wdata = wdata_q;
        cur_wstrb = wstrb_q;
        cur_instr = instr_q;
        if (state_q == S_IDLE) begin
            cur_addr  = mem_addr[31:2];
            cur_wdata = mem_wdata;
            cur_wstrb = mem_wstrb;
            cur_instr = mem_instr;
        end
    end

    assign ram_idx = cur_addr[AW+1:2];
    assign in_ram  = (cur_addr[31:AW+2] == '0);
    assign is_con  = (cur_addr == CON_ADDR);
    assign is_halt = (cur_addr == HALT_ADDR);
    assign is_wr   = |cur_wstrb;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        instr_d     = instr_q;
        rdata_d     = rdata_q;
        out_valid_d = 1'b0;
        out_byte_d  = out_byte_q;
        halt_d      = halt_q;
        err_d       = err_q;
        go_resp     = 1'b0;
        ram_we      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (mem_valid) begin
                    addr_d  = mem_addr[31:2];
                    wdata_d = mem_wdata;
                    wstrb_d = mem_wstrb;
                    instr_d = mem_instr;
                    cnt_d   = WAIT_INIT;
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_RESP;
                        go_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = S_RESP;
                    go_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (go_resp) begin
            if ((is_con || is_halt) && cur_instr) begin
                rdata_d = 32'h0;
                err_d   = 1'b1;
            end else if (in_ram) begin
                rdata_d = ram[ram_idx];
                ram_we  = is_wr && resetn;
            end else if (is_con) begin
                rdata_d = 32'h0;
                if (is_wr) begin
                    out_byte_d  = cur_wdata[7:0];
                    out_valid_d = 1'b1;
                end
            end else if (is_halt) begin
                rdata_d = {31'b0, halt_q};
                if (is_wr) begin
                    halt_d = 1'b1;
                end
            end else begin
                rdata_d = 32'hDEAD_BEEF;
                err_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= '0;
            wdata_q     <= 32'h0;
            wstrb_q     <= 4'h0;
            instr_q     <= 1'b0;
            rdata_q     <= 32'h0;
            out_valid_q <= 1'b0;
            out_byte_q  <= 8'h0;
            halt_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            instr_q     <= instr_d;
            rdata_q     <= rdata_d;
            out_valid_q <= out_valid_d;
            out_byte_q  <= out_byte_d;
            halt_q      <= halt_d;
            err_q       <= err_d;
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (cur_wstrb[i]) begin
                    ram[ram_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
                end
            end
        end
    end

    assign mem_ready = (state_q == S_RESP);
    assign mem_rdata = rdata_q;
    assign out_valid = out_valid_q;
    assign out_byte  = out_byte_q;
    assign halt      = halt_q;
    assign err       = err_q;

endmodule

// File: tb/tb_picorv32_mem_responder.sv
// Directed bench: three responders with 1, 0 and 15 wait states
// on a shared clock and reset.
module tb_picorv32_mem_responder;
    localparam logic [31:0] MB = 32'h1000_0000;

    logic clk = 1'b0;
    logic resetn = 1'b0;

    logic        valid [3];
    logic        rdy   [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [3:0]  wstrb [3];
    logic [31:0] rdata [3];
    logic        instr [3];
    logic        ovld  [3];
    logic [7:0]  obyte [3];
    logic        hlt   [3];
    logic        er    [3];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    picorv32_mem_responder #(.WAIT_CYCLES(1)) dut1 (
        .clk(clk), .resetn(resetn), .mem_valid(valid[1]), .mem_ready(rdy[1]),
        .mem_addr(addr[1]), .mem_wdata(wdata[1]), .mem_wstrb(wstrb[1]),
        .mem_rdata(rdata[1]), .mem_instr(instr[1]), .out_valid(ovld[1]),
        .out_byte(obyte[1]), .halt(hlt[1]), .err(er[1])
    );

    picorv32_mem_responder #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .resetn(resetn), .mem_valid(valid[0]), .mem_ready(rdy[0]),
        .mem_addr(addr[0]), .mem_wdata(wdata[0]), .mem_wstrb(wstrb[0]),
        .mem_rdata(rdata[0]), .mem_instr(instr[0]), .out_valid(ovld[0]),
        .out_byte(obyte[0]), .halt(hlt[0]), .err(er[0])
    );

    picorv32_mem_responder #(.WAIT_CYCLES(15)) dut15 (
        .clk(clk), .resetn(resetn), .mem_valid(valid[2]), .mem_ready(rdy[2]),
        .mem_addr(addr[2]), .mem_wdata(wdata[2]), .mem_wstrb(wstrb[2]),
        .mem_rdata(rdata[2]), .mem_instr(instr[2]), .out_valid(ovld[2]),
        .out_byte(obyte[2]), .halt(hlt[2]), .err(er[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Holds the request until mem_ready, returns data, latency in
    // cycles and out_valid at the ready cycle; checks the pulse width.
    task automatic req(input int d, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] ws,
                       input logic ins, output logic [31:0] rd,
                       output int lat, output logic ov);
        @(negedge clk);
        valid[d] = 1'b1;
        addr[d]  = a;
        wdata[d] = wd;
        wstrb[d] = ws;
        instr[d] = ins;
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (rdy[d]) break;
        end
        rd = rdata[d];
        ov = ovld[d];
        valid[d] = 1'b0;
        wstrb[d] = 4'h0;
        instr[d] = 1'b0;
        @(negedge clk);
        chk("ready_single_pulse", {31'b0, rdy[d]}, 32'h0);
    endtask

    initial begin
        logic [31:0] rd;
        int lat;
        logic ov;

        for (int i = 0; i < 3; i++) begin
            valid[i] = 1'b0;
            addr[i]  = 32'h0;
            wdata[i] = 32'h0;
            wstrb[i] = 4'h0;
            instr[i] = 1'b0;
        end

        #2;
        chk("rst_ready", {31'b0, rdy[1]}, 32'h0);
        chk("rst_rdata", rdata[1], 32'h0);
        chk("rst_out_valid", {31'b0, ovld[1]}, 32'h0);
        chk("rst_out_byte", {24'b0, obyte[1]}, 32'h0);
        chk("rst_halt", {31'b0, hlt[1]}, 32'h0);
        chk("rst_err", {31'b0, er[1]}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;

        req(1, 32'h10, 32'h1234_5678, 4'hF, 1'b0, rd, lat, ov);
        chk("w1_write_lat", lat, 32'd2);
        req(1, 32'h10, 32'h0, 4'h0, 1'b0, rd, lat, ov);
        chk("w1_read_lat", lat, 32'd2);
        chk("w1_read_data", rd, 32'h1234_5678);

        req(1, 32'h20, 32'hAABB_CCDD, 4'hF, 1'b0, rd, lat, ov);
        req(1, 32'h20, 32'h0000_EE00, 4'b0010, 1'b0, rd, lat, ov);
        chk("lane_write_prewrite", rd, 32'hAABB_CCDD);
        req(1, 32'h20, 32'h0, 4'h0, 1'b0, rd, lat, ov);
        chk("lane_merge", rd, 32'hAABB_EEDD);

        req(1, MB, 32'h41, 4'hF, 1'b0, rd, lat, ov);
        chk("con_pulse", {31'b0, ov}, 32'h1);
        chk("con_pulse_end", {31'b0, ovld[1]}, 32'h0);
        chk("con_byte", {24'b0, obyte[1]}, 32'h41);
        req(1, MB, 32'h0, 4'h0, 1'b0, rd, lat, ov);
        chk("con_read", rd, 32'h0);
        chk("con_read_no_pulse", {31'b0, ov}, 32'h0);
        chk("con_byte_held", {24'b0, obyte[1]}, 32'h41);

        req(1, MB + 32'd4, 32'h0, 4'h0, 1'b0, rd, lat, ov);
        chk("halt_read0", rd, 32'h0);
        req(1, MB + 32'd4, 32'h0, 4'hF, 1'b0, rd, lat, ov);
        chk("halt_set", {31'b0, hlt[1]}, 32'h1);
        req(1, MB + 32'd4, 32'h0, 4'h0, 1'b0, rd, lat, ov);
        chk("halt_read1", rd, 32'h1);
        repeat (5) @(negedge clk);
        chk("halt_sticky", {31'b0, hlt[1]}, 32'h1);
        chk("err_clear_mmio", {31'b0, er[1]}, 32'h0);

        req(1, 32'h2000_0000, 32'h0, 4'h0, 1'b0, rd, lat, ov);
        chk("oor_data", rd, 32'hDEAD_BEEF);
        chk("oor_lat", lat, 32'd2);
        chk("oor_err", {31'b0, er[1]}, 32'h1);
        req(1, 32'h10, 32'h0, 4'h0, 1'b0, rd, lat, ov);
        chk("after_oor_read", rd, 32'h1234_5678);

        req(0, 32'h40, 32'h0BAD_F00D, 4'hF, 1'b0, rd, lat, ov);
        chk("w0_write_lat", lat, 32'd1);
        for (int k = 0; k < 3; k++) begin
            req(0, 32'h40, 32'h0, 4'h0, 1'b0, rd, lat, ov);
            chk("w0_read_lat", lat, 32'd1);
            chk("w0_read_data", rd, 32'h0BAD_F00D);
        end
        chk("w0_err_clean", {31'b0, er[0]}, 32'h0);
        req(0, MB + 32'd4, 32'h0, 4'h0, 1'b1, rd, lat, ov);
        chk("mmio_fetch_data", rd, 32'h0);
        chk("mmio_fetch_err", {31'b0, er[0]}, 32'h1);

        req(2, 32'h8, 32'h5555_AAAA, 4'hF, 1'b0, rd, lat, ov);
        chk("w15_write_lat", lat, 32'd16);
        req(2, 32'h8, 32'h0, 4'h0, 1'b0, rd, lat, ov);
        chk("w15_read_lat", lat, 32'd16);
        chk("w15_read_data", rd, 32'h5555_AAAA);
        req(2, 32'h8, 32'h0, 4'h0, 1'b0, rd, lat, ov);
        chk("w15_read2_lat", lat, 32'd16);

        req(1, 32'h30, 32'hCAFE_0030, 4'hF, 1'b0, rd, lat, ov);
        @(negedge clk);
        valid[1] = 1'b1;
        addr[1]  = 32'h30;
        wdata[1] = 32'hFFFF_FFFF;
        wstrb[1] = 4'hF;
        @(negedge clk);
        chk("mid_in_wait", {31'b0, rdy[1]}, 32'h0);
        resetn   = 1'b0;
        valid[1] = 1'b0;
        wstrb[1] = 4'h0;
        #1;
        chk("mid_rst_rdata", rdata[1], 32'h0);
        chk("mid_rst_halt", {31'b0, hlt[1]}, 32'h0);
        chk("mid_rst_err", {31'b0, er[1]}, 32'h0);
        chk("mid_rst_byte", {24'b0, obyte[1]}, 32'h0);
        chk("mid_rst_ovalid", {31'b0, ovld[1]}, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("mid_rst_no_ready", {31'b0, rdy[1]}, 32'h0);
        end
        resetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rst_no_ready", {31'b0, rdy[1]}, 32'h0);
        end
        req(1, 32'h30, 32'h0, 4'h0, 1'b0, rd, lat, ov);
        chk("store_not_committed", rd, 32'hCAFE_0030);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
